// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait holds with a timeout that latches a sticky error state.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RT_i,
  input  logic [4:0]       IF_ID_RS_i,
  input  logic [4:0]       IF_ID_RT_i,
  input  logic             EX_MEM_MemAccess_i,
  input  logic             dmem_ready_i,
  input  logic             Branch_taken_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             Pipe_Hold_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Flush_o,
  output logic             EX_MEM_Flush_o,
  output logic             MEM_WB_Bubble_o,
  output logic             PC_Src_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [7:0] timer;
  logic [7:0] timer_next;

  logic mem_wait;
  logic load_use;
  logic do_hold;
  logic do_branch;
  logic do_load_use;

  // Memory handshake: an access in MEM completes in the cycle where
  // EX_MEM_MemAccess_i and dmem_ready_i are both high; until then the
  // pipeline behind MEM is frozen and MEM/WB takes bubbles.
  assign mem_wait = EX_MEM_MemAccess_i && !dmem_ready_i;
  assign load_use = ID_EX_MemRead_i && (ID_EX_RT_i != 5'd0) &&
                    ((ID_EX_RT_i == IF_ID_RS_i) || (ID_EX_RT_i == IF_ID_RT_i));

  always_comb begin
    state_next  = state;
    timer_next  = timer;
    do_hold     = 1'b0;
    do_branch   = 1'b0;
    do_load_use = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          do_hold    = 1'b1;
          timer_next = 8'd1;
          state_next = MEMWAIT;
        end else if (Branch_taken_i) begin
          do_branch = 1'b1;
        end else if (load_use) begin
          do_load_use = 1'b1;
        end
      end
      MEMWAIT: begin
        if (!dmem_ready_i) begin
          do_hold = 1'b1;
          if (timer == TIMEOUT) begin
            state_next = ERR;
          end else begin
            timer_next = timer + 8'd1;
          end
        end else begin
          // Release cycle: the held instruction in ID may still need a flush or stall.
          state_next = RUN;
          timer_next = 8'd0;
          if (Branch_taken_i) begin
            do_branch = 1'b1;
          end else if (load_use) begin
            do_load_use = 1'b1;
          end
        end
      end
      ERR: begin
        do_hold = 1'b1;
      end
      default: begin
        state_next = RUN;
        timer_next = 8'd0;
      end
    endcase
  end

  always_comb begin
    PC_Write_o      = 1'b1;
    IF_ID_Write_o   = 1'b1;
    Pipe_Hold_o     = 1'b0;
    IF_ID_Flush_o   = 1'b0;
    ID_EX_Flush_o   = 1'b0;
    EX_MEM_Flush_o  = 1'b0;
    MEM_WB_Bubble_o = 1'b0;
    PC_Src_o        = 1'b0;
    err_o           = (state == ERR);
    if (!rst_i) begin
      PC_Write_o      = 1'b0;
      IF_ID_Write_o   = 1'b0;
      IF_ID_Flush_o   = 1'b1;
      ID_EX_Flush_o   = 1'b1;
      EX_MEM_Flush_o  = 1'b1;
      MEM_WB_Bubble_o = 1'b1;
    end else if (do_hold) begin
      PC_Write_o      = 1'b0;
      IF_ID_Write_o   = 1'b0;
      Pipe_Hold_o     = 1'b1;
      MEM_WB_Bubble_o = 1'b1;
    end else if (do_branch) begin
      PC_Src_o       = 1'b1;
      IF_ID_Flush_o  = 1'b1;
      ID_EX_Flush_o  = 1'b1;
      EX_MEM_Flush_o = 1'b1;
    end else if (do_load_use) begin
      PC_Write_o    = 1'b0;
      IF_ID_Write_o = 1'b0;
      ID_EX_Flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= RUN;
      timer       <= 8'd0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      // Counters stick at all-ones rather than wrapping.
      if (!PC_Write_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (do_branch && (flush_cnt_o != {CNT_W{1'b1}})) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: a directed vector table, hand sequences for
// timeout and saturation, and random traffic against a reference model.
module tb_hazard_controller;

  localparam logic [8:0] DEF = 9'b110000000;
  localparam logic [8:0] RSO = 9'b000111100;
  localparam logic [8:0] LUO = 9'b000010000;
  localparam logic [8:0] BRO = 9'b110111010;
  localparam logic [8:0] HLD = 9'b001000100;

  logic       clk;
  logic       rst, mr, ma, rdy, br;
  logic [4:0] ex_rt, rs, rt;

  logic pcw_a, ifw_a, hold_a, iff_a, idf_a, emf_a, bub_a, src_a, err_a;
  logic pcw_b, ifw_b, hold_b, iff_b, idf_b, emf_b, bub_b, src_b, err_b;
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;
  logic [1:0]  dbg_a, dbg_b;
  logic [8:0]  out_a, out_b;

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, count of consecutive held cycles and a dead flag.
  int tmo[2]   = '{255, 4};
  int cmax[2]  = '{65535, 15};
  int waited[2];
  bit dead[2];
  int stall[2];
  int flush[2];

  hazard_controller dut_a (
    .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(mr), .ID_EX_RT_i(ex_rt),
    .IF_ID_RS_i(rs), .IF_ID_RT_i(rt), .EX_MEM_MemAccess_i(ma),
    .dmem_ready_i(rdy), .Branch_taken_i(br),
    .PC_Write_o(pcw_a), .IF_ID_Write_o(ifw_a), .Pipe_Hold_o(hold_a),
    .IF_ID_Flush_o(iff_a), .ID_EX_Flush_o(idf_a), .EX_MEM_Flush_o(emf_a),
    .MEM_WB_Bubble_o(bub_a), .PC_Src_o(src_a), .err_o(err_a),
    .stall_cnt_o(stall_a), .flush_cnt_o(flush_a), .dbg_state_o(dbg_a)
  );

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(mr), .ID_EX_RT_i(ex_rt),
    .IF_ID_RS_i(rs), .IF_ID_RT_i(rt), .EX_MEM_MemAccess_i(ma),
    .dmem_ready_i(rdy), .Branch_taken_i(br),
    .PC_Write_o(pcw_b), .IF_ID_Write_o(ifw_b), .Pipe_Hold_o(hold_b),
    .IF_ID_Flush_o(iff_b), .ID_EX_Flush_o(idf_b), .EX_MEM_Flush_o(emf_b),
    .MEM_WB_Bubble_o(bub_b), .PC_Src_o(src_b), .err_o(err_b),
    .stall_cnt_o(stall_b), .flush_cnt_o(flush_b), .dbg_state_o(dbg_b)
  );

  assign out_a = {pcw_a, ifw_a, hold_a, iff_a, idf_a, emf_a, bub_a, src_a, err_a};
  assign out_b = {pcw_b, ifw_b, hold_b, iff_b, idf_b, emf_b, bub_b, src_b, err_b};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_out(input int k);
    logic lu;
    logic held;
    if (!rst) return RSO | {8'b0, dead[k]};
    if (dead[k]) return HLD | 9'b1;
    lu = mr && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
    held = (waited[k] > 0) ? !rdy : (ma && !rdy);
    if (held) return HLD;
    if (br) return BRO;
    if (lu) return LUO;
    return DEF;
  endfunction

  task automatic model_update(input int k);
    logic [8:0] o;
    o = model_out(k);
    if (!rst) begin
      waited[k] = 0;
      dead[k]   = 1'b0;
      stall[k]  = 0;
      flush[k]  = 0;
    end else begin
      if (!o[8] && stall[k] < cmax[k]) stall[k]++;
      if (o[3] && flush[k] < cmax[k]) flush[k]++;
      if (!dead[k]) begin
        if (o[6]) begin
          waited[k]++;
          if (waited[k] > tmo[k]) dead[k] = 1'b1;
        end else begin
          waited[k] = 0;
        end
      end
    end
  endtask

  // Called at a negedge with inputs already driven; compares, then crosses one posedge.
  task automatic step();
    #1;
    check("out_a", 32'(out_a), 32'(model_out(0)));
    check("out_b", 32'(out_b), 32'(model_out(1)));
    check("stall_a", 32'(stall_a), 32'(stall[0]));
    check("flush_a", 32'(flush_a), 32'(flush[0]));
    check("stall_b", 32'(stall_b), 32'(stall[1]));
    check("flush_b", 32'(flush_b), 32'(flush[1]));
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic m, input logic [4:0] e,
                       input logic [4:0] s, input logic [4:0] t,
                       input logic a, input logic d, input logic b);
    rst = r; mr = m; ex_rt = e; rs = s; rt = t; ma = a; rdy = d; br = b;
  endtask

  typedef struct {
    logic       r, m;
    logic [4:0] e, s, t;
    logic       a, d, b;
    logic [8:0] exp;
    int         sc, fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic m, input logic [4:0] e,
                              input logic [4:0] s, input logic [4:0] t,
                              input logic a, input logic d, input logic b,
                              input logic [8:0] exp, input int sc, input int fc);
    vec_t v;
    v.r = r; v.m = m; v.e = e; v.s = s; v.t = t;
    v.a = a; v.d = d; v.b = b; v.exp = exp; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      waited[k] = 0; dead[k] = 1'b0; stall[k] = 0; flush[k] = 0;
    end

    // Directed vectors; counter expectations are the values before the edge.
    tbl.push_back(mk(0, 0,  0, 0,  0, 0, 0, 0, RSO, 0, 0));
    tbl.push_back(mk(1, 0,  0, 0,  0, 0, 1, 0, DEF, 0, 0));
    tbl.push_back(mk(1, 1,  5, 5,  0, 0, 1, 0, LUO, 0, 0));
    tbl.push_back(mk(1, 0,  5, 5,  0, 0, 1, 0, DEF, 1, 0));
    tbl.push_back(mk(1, 1,  0, 0,  0, 0, 1, 0, DEF, 1, 0));
    tbl.push_back(mk(1, 1,  7, 3,  7, 0, 1, 1, BRO, 1, 0));
    tbl.push_back(mk(1, 0,  0, 0,  0, 0, 1, 0, DEF, 1, 1));
    tbl.push_back(mk(1, 0,  0, 0,  0, 1, 0, 0, HLD, 1, 1));
    tbl.push_back(mk(1, 0,  0, 0,  0, 1, 0, 0, HLD, 2, 1));
    tbl.push_back(mk(1, 0,  0, 0,  0, 1, 0, 0, HLD, 3, 1));
    tbl.push_back(mk(1, 0,  0, 0,  0, 1, 1, 0, DEF, 4, 1));
    tbl.push_back(mk(1, 0,  0, 0,  0, 0, 1, 0, DEF, 4, 1));
    tbl.push_back(mk(1, 0,  0, 0,  0, 1, 0, 1, HLD, 4, 1));
    tbl.push_back(mk(1, 0,  0, 0,  0, 1, 1, 1, BRO, 5, 1));
    tbl.push_back(mk(1, 0,  0, 0,  0, 0, 1, 0, DEF, 5, 2));
    tbl.push_back(mk(1, 0,  0, 0,  0, 1, 0, 0, HLD, 5, 2));
    tbl.push_back(mk(1, 1,  9, 9,  0, 1, 1, 0, LUO, 6, 2));
    tbl.push_back(mk(1, 0,  0, 0,  0, 0, 1, 0, DEF, 7, 2));
    tbl.push_back(mk(1, 0,  0, 0,  0, 1, 0, 0, HLD, 7, 2));
    tbl.push_back(mk(0, 0,  0, 0,  0, 1, 0, 0, RSO, 8, 2));
    tbl.push_back(mk(1, 0,  0, 0,  0, 0, 1, 0, DEF, 0, 0));
    tbl.push_back(mk(1, 1, 12, 3, 12, 0, 1, 0, LUO, 0, 0));
    tbl.push_back(mk(1, 0,  0, 0,  0, 0, 1, 0, DEF, 1, 0));
    tbl.push_back(mk(1, 1, 12, 3,  4, 0, 1, 0, DEF, 1, 0));
    tbl.push_back(mk(1, 0, 12, 12, 12, 0, 1, 0, DEF, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].m, tbl[i].e, tbl[i].s, tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].b);
      #1;
      check($sformatf("vec%0d_out", i), 32'(out_a), 32'(tbl[i].exp));
      check($sformatf("vec%0d_stall", i), 32'(stall_a), 32'(tbl[i].sc));
      check($sformatf("vec%0d_flush", i), 32'(flush_a), 32'(tbl[i].fc));
      step();
    end

    // Timeout on the MEM_TIMEOUT=4 instance: five hold cycles, then sticky error.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("timeout_pre_err", 32'(err_b), 32'd0);
      check("timeout_hold", 32'(hold_b), 32'd1);
      step();
    end
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("timeout_err", 32'(err_b), 32'd1);
      check("timeout_err_hold", 32'(out_b), 32'(HLD | 9'b1));
      check("timeout_a_release", 32'(out_a), 32'(BRO));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    #1;
    check("err_cleared", 32'(err_b), 32'd0);
    check("err_clear_out", 32'(out_b), 32'(DEF));
    check("err_clear_stall", 32'(stall_b), 32'd0);
    check("err_clear_flush", 32'(flush_b), 32'd0);
    step();

    // Saturation: 20 stalls and 20 branch flushes.
    drive(1, 1, 3, 3, 0, 0, 1, 0);
    repeat (20) step();
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    repeat (20) step();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    #1;
    check("sat_stall_a", 32'(stall_a), 32'd20);
    check("sat_stall_b", 32'(stall_b), 32'd15);
    check("sat_flush_a", 32'(flush_a), 32'd20);
    check("sat_flush_b", 32'(flush_b), 32'd15);
    step();

    // Random traffic with occasional resets, small register range for collisions.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 59) != 0);
      mr    = $urandom_range(0, 1);
      ex_rt = 5'($urandom_range(0, 3));
      rs    = 5'($urandom_range(0, 3));
      rt    = 5'($urandom_range(0, 3));
      ma    = ($urandom_range(0, 2) == 0);
      rdy   = ($urandom_range(0, 4) >= 2);
      br    = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
